// File: rtl/eth_fcs_tx_ctrl.sv
// Ethernet TX FCS sequencer: passes frame bytes, zero-pads short frames,
// then appends the FCS read from an external crc32 instance.
module eth_fcs_tx_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int MIN_FRAME_LEN = 60,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  crc_rst,
    output logic                  crc_en,
    output logic [DATA_WIDTH-1:0] crc_byte,
    output logic                  crc_eof,
    input  logic [31:0]           crc_in
);

    typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_t;

    localparam logic [CNT_WIDTH:0] MIN_LEN = (CNT_WIDTH+1)'(MIN_FRAME_LEN);

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] byte_cnt, cnt_n, cnt_sat;
    logic [CNT_WIDTH:0]   cnt_inc;
    logic [1:0]           fcs_idx, idx_n;
    logic                 rst_q, xfer, at_min;

    // One extra bit lets the minimum check see the true count past saturation.
    assign cnt_inc = {1'b0, byte_cnt} + (CNT_WIDTH+1)'(1);
    assign cnt_sat = cnt_inc[CNT_WIDTH] ? byte_cnt : cnt_inc[CNT_WIDTH-1:0];
    assign at_min  = (cnt_inc >= MIN_LEN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            byte_cnt <= '0;
            fcs_idx  <= '0;
            rst_q    <= 1'b1;
        end else begin
            state    <= state_n;
            byte_cnt <= cnt_n;
            fcs_idx  <= idx_n;
            rst_q    <= 1'b0;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = byte_cnt;
        idx_n    = fcs_idx;
        s_tready = 1'b0;
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        crc_rst  = rst_q;
        crc_en   = 1'b0;
        crc_byte = '0;
        crc_eof  = 1'b0;
        xfer     = 1'b0;
        case (state)
            IDLE, DATA: begin
                m_tdata  = s_tdata;
                m_tvalid = s_tvalid;
                s_tready = m_tready;
                xfer     = s_tvalid & m_tready;
                if (xfer) begin
                    crc_en   = 1'b1;
                    crc_byte = s_tdata;
                    cnt_n    = cnt_sat;
                    state_n  = DATA;
                    if (s_tlast) begin
                        state_n = at_min ? FCS : PAD;
                        idx_n   = '0;
                    end
                end
            end
            PAD: begin
                m_tvalid = 1'b1;
                xfer     = m_tready;
                if (xfer) begin
                    crc_en = 1'b1;
                    cnt_n  = cnt_sat;
                    if (at_min) begin
                        state_n = FCS;
                        idx_n   = '0;
                    end
                end
            end
            FCS: begin
                m_tvalid = 1'b1;
                crc_eof  = 1'b1;
                m_tdata  = DATA_WIDTH'(crc_in[{fcs_idx, 3'b000} +: 8]);
                m_tlast  = (fcs_idx == 2'd3);
                xfer     = m_tready;
                if (xfer) begin
                    idx_n = fcs_idx + 2'd1;
                    if (fcs_idx == 2'd3) begin
                        crc_rst = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Outputs stay quiet while reset is held, whatever the source presents.
        if (reset) begin
            s_tready = 1'b0;
            m_tdata  = '0;
            m_tvalid = 1'b0;
            m_tlast  = 1'b0;
            crc_rst  = 1'b1;
            crc_en   = 1'b0;
            crc_byte = '0;
            crc_eof  = 1'b0;
        end
    end

endmodule

// File: tb/tb_eth_fcs_tx_ctrl.sv
// Scoreboard bench for eth_fcs_tx_ctrl: three instances (no padding, default,
// tiny saturating counter), each wired to a behavioural crc32.
module tb_eth_fcs_tx_ctrl;

    localparam int N = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  s_tdata [N];
    logic        s_tvalid[N];
    logic        s_tlast [N];
    logic        s_tready[N];
    logic [7:0]  m_tdata [N];
    logic        m_tvalid[N];
    logic        m_tlast [N];
    logic        m_tready[N];
    logic        crc_rst [N];
    logic        crc_en  [N];
    logic [7:0]  crc_byte[N];
    logic        crc_eof [N];
    logic [31:0] crc_in  [N];
    bit          stall   [N];

    logic [8:0] q[N][$];
    int vectors = 0;
    int errs = 0;

    function automatic logic [31:0] crc_step(logic [31:0] c, logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Reference FCS over a whole frame: standard reflected CRC-32, inverted.
    function automatic logic [31:0] fcs_of(logic [7:0] f[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (f[i]) c = crc_step(c, f[i]);
        return ~c;
    endfunction

    function automatic int min_of(int g);
        return (g == 0) ? 0 : (g == 1) ? 60 : 10;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic expect_frame(int g, input logic [7:0] p[$]);
        logic [7:0]  f[$];
        logic [31:0] fcs;
        f = p;
        while (f.size() < min_of(g)) f.push_back(8'h00);
        fcs = fcs_of(f);
        foreach (f[i]) q[g].push_back({1'b0, f[i]});
        for (int k = 0; k < 4; k++)
            q[g].push_back({k == 3, fcs[8*k +: 8]});
    endtask

    task automatic send(int g, input logic [7:0] p[$], input bit gaps,
                        input bit last = 1'b1);
        bit ok;
        int n;
        for (int i = 0; i < p.size(); i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                s_tvalid[g] = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            s_tvalid[g] = 1'b1;
            s_tdata[g]  = p[i];
            s_tlast[g]  = last && (i == p.size() - 1);
            n = 0;
            do begin
                @(negedge clk);
                ok = s_tready[g];
                @(posedge clk);
                #1;
                n++;
            end while (!ok && n < 1000);
            if (!ok) begin
                vectors++;
                errs++;
                $display("FAIL accept_timeout g%0d byte %0d: got no s_tready required s_tready", g, i);
                break;
            end
        end
        s_tvalid[g] = 1'b0;
        s_tlast[g]  = 1'b0;
    endtask

    task automatic drain(int g);
        int n = 0;
        while (q[g].size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("drain_g%0d", g), q[g].size(), 0);
    endtask

    task automatic rand_payload(output logic [7:0] p[$], input int len);
        p.delete();
        repeat (len) p.push_back(8'($urandom));
    endtask

    task automatic check_reset_outputs();
        for (int g = 0; g < N; g++) begin
            chk($sformatf("rst_outs_g%0d", g),
                {s_tready[g], m_tvalid[g], m_tlast[g], crc_en[g], crc_eof[g],
                 m_tdata[g], crc_byte[g], crc_rst[g]},
                {5'b0, 8'h00, 8'h00, 1'b1});
        end
    endtask

    task automatic do_reset();
        for (int g = 0; g < N; g++) begin
            s_tvalid[g] = 1'b1;
            s_tdata[g]  = 8'hA5;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) s_tvalid[g] = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("crc_rst_held_g1", crc_rst[1], 1'b1);
        @(negedge clk);
        chk("crc_rst_drop_g1", crc_rst[1], 1'b0);
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < N; g++) begin : gi
        localparam int MIN = (g == 0) ? 0 : (g == 1) ? 60 : 10;
        localparam int CW  = (g == 2) ? 4 : 16;
        logic [31:0] crc_reg;

        eth_fcs_tx_ctrl #(
            .DATA_WIDTH(8), .MIN_FRAME_LEN(MIN), .CNT_WIDTH(CW)
        ) dut (
            .clk(clk), .reset(reset),
            .s_tdata(s_tdata[g]), .s_tvalid(s_tvalid[g]),
            .s_tlast(s_tlast[g]), .s_tready(s_tready[g]),
            .m_tdata(m_tdata[g]), .m_tvalid(m_tvalid[g]),
            .m_tlast(m_tlast[g]), .m_tready(m_tready[g]),
            .crc_rst(crc_rst[g]), .crc_en(crc_en[g]),
            .crc_byte(crc_byte[g]), .crc_eof(crc_eof[g]),
            .crc_in(crc_in[g])
        );

        // Behavioural crc32: synchronous clear, byte update, eof gives the FCS word.
        always @(posedge clk) begin
            if (crc_rst[g]) crc_reg <= 32'hFFFFFFFF;
            else if (crc_en[g]) crc_reg <= crc_step(crc_reg, crc_byte[g]);
        end
        assign crc_in[g] = crc_eof[g] ? ~crc_reg : crc_reg;

        initial begin
            s_tvalid[g] = 1'b0;
            s_tlast[g]  = 1'b0;
            s_tdata[g]  = 8'h00;
            m_tready[g] = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                m_tready[g] = stall[g] ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end

        always @(negedge clk) begin : mon
            bit x;
            logic [8:0] e;
            if (!reset) begin
                x = m_tvalid[g] && m_tready[g];
                chk($sformatf("crc_en_g%0d", g), crc_en[g], x && !crc_eof[g]);
                if (crc_eof[g])
                    chk($sformatf("s_tready_fcs_g%0d", g), s_tready[g], 1'b0);
                if (x) begin
                    if (q[g].size() == 0) begin
                        vectors++;
                        errs++;
                        $display("FAIL extra_byte_g%0d: got %h expected none", g, m_tdata[g]);
                    end else begin
                        e = q[g].pop_front();
                        chk($sformatf("out_g%0d", g), {m_tlast[g], m_tdata[g]}, e);
                        if (m_tlast[g])
                            chk($sformatf("crc_rst_last_g%0d", g), crc_rst[g], 1'b1);
                        if (crc_en[g])
                            chk($sformatf("crc_byte_g%0d", g), crc_byte[g], m_tdata[g]);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] p[$], p2[$], pb[$];
        int g;

        do_reset();

        // "123456789" with no padding: known CRC-32 CBF43926, sent LSB first.
        p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        foreach (p[i]) q[0].push_back({1'b0, p[i]});
        q[0].push_back({1'b0, 8'h26});
        q[0].push_back({1'b0, 8'h39});
        q[0].push_back({1'b0, 8'hF4});
        q[0].push_back({1'b1, 8'hCB});
        send(0, p, 1'b0);
        drain(0);

        rand_payload(p2, 14);
        expect_frame(1, p2);
        send(1, p2, 1'b0);
        drain(1);

        rand_payload(p, 60);
        expect_frame(1, p);
        send(1, p, 1'b0);
        drain(1);

        stall[1] = 1'b1;
        expect_frame(1, p2);
        send(1, p2, 1'b1);
        drain(1);
        stall[1] = 1'b0;

        // Back-to-back: second frame's first byte waits through PAD/FCS.
        rand_payload(p, 30);
        rand_payload(pb, 65);
        expect_frame(1, p);
        expect_frame(1, pb);
        send(1, p, 1'b0);
        send(1, pb, 1'b0);
        drain(1);

        rand_payload(p, 1);
        expect_frame(1, p);
        send(1, p, 1'b0);
        expect_frame(0, p);
        send(0, p, 1'b0);
        drain(1);
        drain(0);

        // Abort mid-frame with reset, then a clean frame.
        rand_payload(p, 20);
        foreach (p[i]) q[1].push_back({1'b0, p[i]});
        send(1, p, 1'b0, 1'b0);
        drain(1);
        do_reset();
        rand_payload(p, 60);
        expect_frame(1, p);
        send(1, p, 1'b0);
        drain(1);

        // Tiny counter saturates at 15; frames still pass whole.
        stall[2] = 1'b1;
        foreach (p2[i]) p2[i] = p2[i];
        for (int k = 0; k < 4; k++) begin
            rand_payload(p, (k == 0) ? 20 : (k == 1) ? 5 : (k == 2) ? 10 : 40);
            expect_frame(2, p);
            send(2, p, 1'b1);
        end
        drain(2);
        stall[2] = 1'b0;

        for (int k = 0; k < 8; k++) begin
            g = k % 2;
            stall[g] = ($urandom_range(0, 1) == 1);
            rand_payload(p, $urandom_range(1, 80));
            expect_frame(g, p);
            send(g, p, stall[g]);
            drain(g);
            stall[g] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
